mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Load/store controller directly upstream of the 64x32 data RAM. It drives the RAM's write enable, 6-bit word address and 32-bit write data, and consumes its 32-bit read data.
- Accepts CPU-side byte-addressed requests (lb/lbu/lh/lhu/lw/sb/sh/sw) over a valid/ready handshake.
- Hides the RAM's 1-cycle registered read latency and performs read-modify-write for sub-word stores.
- Byte lanes are little-endian: byte 0 is bits [7:0].

Parameters:
- ADDR_W, 8, byte address width; word index = addr[ADDR_W-1:2] (6 bits at default)
- DATA_W, 32, data width; fixed at 32 (byte lanes assume 4 bytes)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data; the value is in the low bits for byte/half
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load result; 0 for stores
- resp_err  output  1  misaligned-access flag (see Optional Feature)
- mem_we  output  1  to RAM write enable
- mem_addr  output  6  to RAM word address
- mem_wdata  output  32  to RAM write data
- mem_rdata  input  32  from RAM read data; valid the cycle after mem_addr is sampled

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; all latched request registers cleared.
  - resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_wdata=0.
  - mem_we is combinationally ANDed with rst_n, so no RAM write occurs in any cycle where rst_n=0, even mid-RMW.
- States: IDLE, RD, MERGE, CAP, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, latch we/size/unsigned/addr/wdata (cycle T0), then go to:
    - WR for a word store.
    - RD for any load or sub-word store.
- RD:
  - mem_addr = latched addr[7:2], mem_we=0.
  - Next state: CAP for a load, MERGE for a sub-word store.
- CAP (load):
  - Select the lane from mem_rdata: byte uses addr[1:0], half uses addr[1], word takes all 32 bits.
  - Sign- or zero-extend per the latched unsigned bit, register the result, go to RESP.
- MERGE (sb/sh):
  - Replace the addressed lane(s) of mem_rdata with wdata[7:0] or wdata[15:0].
  - Register the merged word into mem_wdata, go to WR.
- WR:
  - mem_we=1 for exactly one cycle.
  - mem_addr = latched word index.
  - mem_wdata = merged word, or wdata for sw.
  - Go to RESP.
- RESP: resp_valid=1 for one cycle with resp_rdata/resp_err, then IDLE. There is no response backpressure.
- Latency from the accept edge to resp_valid high:
  - sw: 2 cycles.
  - load: 3 cycles.
  - sb/sh: 4 cycles.
  - The next request is acceptable the cycle after RESP.
- mem_addr and mem_wdata hold their last values in IDLE; mem_we=0 in every state except WR.
- Alignment without the macro: half ignores addr[0]; word ignores addr[1:0].
- req_valid asserted outside IDLE is ignored (req_ready=0). Request inputs are only sampled at the accept edge.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0]=1, or a word/reserved access with addr[1:0]!=0, skips all RAM activity (no RD, no WR) and goes from IDLE directly to RESP.
  - The response is resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept. RAM contents are untouched.
- Undefined: resp_err is tied to 0; misaligned addresses are silently truncated as described in Behaviour.

Test Plan:
- Word round-trip: sw addr=0x10 wdata=0xDEADBEEF. Required: mem_we pulse with mem_addr=4, resp_valid 2 cycles after accept. Then lw 0x10 gives resp_rdata=0xDEADBEEF, resp_valid 3 cycles after accept.
- Byte RMW: with word 4 = 0x11223344, sb addr=0x12 wdata=0xA5. Required: one RD, then WR of 0x11A53344, resp_valid 4 cycles after accept. lbu 0x12 gives 0x000000A5; lb 0x12 gives 0xFFFFFFA5.
- Half loads: with word 4 = 0x8001_7FFE, lh 0x12 gives 0xFFFF8001; lhu 0x12 gives 0x00008001; lh 0x10 gives 0x00007FFE.
- Handshake: hold req_valid high for back-to-back requests. Required: req_ready low from the accept through RESP, the second request accepted the cycle after the first resp_valid, no request lost or duplicated.
- Reset mid-RMW: drop rst_n during the WR cycle of an sb. Required: mem_we=0 in that cycle, word unchanged, state IDLE, all outputs at reset values, no resp_valid.
- MISALIGN_TRAP_EN defined: lw 0x13 gives resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept, no mem_we. Undefined: the same lw returns word 4 with resp_err=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store controller in front of a 64x32 RAM with sub-word RMW
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses return resp_err without touching the RAM.
module mem_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_MERGE, S_CAP, S_WR, S_RESP} state_t;

  state_t            r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [1:0]        r_addr_lo;
  logic [15:0]       r_wdata_lo;
  logic [ADDR_W-3:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merged;

`ifdef MISALIGN_TRAP_EN
  logic r_err;
  logic w_misalign;
  assign w_misalign = (req_size == 2'd1) ? req_addr[0] : (req_size[1] && (req_addr[1:0] != 2'b00));
  assign resp_err   = r_err;
`else
  assign resp_err   = 1'b0;
`endif

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  // Gating with rst_n keeps a reset landing in WR from committing a half-finished RMW.
  assign mem_we     = (r_state == S_WR) && rst_n;

  always_comb begin
    w_byte = 8'h00;
    case (r_addr_lo)
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      2'd3: w_byte = mem_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      2'd0:    w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'd1:    w_load = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_comb begin
    w_merged = mem_rdata;
    if (r_size == 2'd0) begin
      case (r_addr_lo)
        2'd0: w_merged[7:0]   = r_wdata_lo[7:0];
        2'd1: w_merged[15:8]  = r_wdata_lo[7:0];
        2'd2: w_merged[23:16] = r_wdata_lo[7:0];
        2'd3: w_merged[31:24] = r_wdata_lo[7:0];
        default: w_merged = mem_rdata;
      endcase
    end else if (r_addr_lo[1]) begin
      w_merged[31:16] = r_wdata_lo;
    end else begin
      w_merged[15:0] = r_wdata_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'd0;
      r_uns        <= 1'b0;
      r_addr_lo    <= 2'd0;
      r_wdata_lo   <= 16'h0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
`ifdef MISALIGN_TRAP_EN
      r_err        <= 1'b0;
`endif
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_uns      <= req_unsigned;
            r_addr_lo  <= req_addr[1:0];
            r_wdata_lo <= req_wdata[15:0];
`ifdef MISALIGN_TRAP_EN
            if (w_misalign) begin
              r_resp_valid <= 1'b1;
              r_resp_rdata <= '0;
              r_err        <= 1'b1;
              r_state      <= S_RESP;
            end else begin
`else
            begin
`endif
              r_mem_addr <= req_addr[ADDR_W-1:2];
              if (req_we && req_size[1]) begin
                r_mem_wdata <= req_wdata;
                r_state     <= S_WR;
              end else begin
                r_state <= S_RD;
              end
            end
          end
        end
        S_RD: r_state <= r_we ? S_MERGE : S_CAP;
        S_CAP: begin
          r_resp_rdata <= w_load;
          r_resp_valid <= 1'b1;
`ifdef MISALIGN_TRAP_EN
          r_err        <= 1'b0;
`endif
          r_state      <= S_RESP;
        end
        S_MERGE: begin
          r_mem_wdata <= w_merged;
          r_state     <= S_WR;
        end
        S_WR: begin
          r_resp_rdata <= '0;
          r_resp_valid <= 1'b1;
`ifdef MISALIGN_TRAP_EN
          r_err        <= 1'b0;
`endif
          r_state      <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
